// File: rtl/if_id_pipe_stage_if.sv
// Fetch-to-decode handshake bundle: upstream valid/ready with PC/instruction,
// flush, and downstream valid/ready with the registered payload.
interface if_id_pipe_stage_if #(
   parameter int unsigned PC_W    = 10,
   parameter int unsigned INSTR_W = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr
   );
endinterface

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register with valid/ready handshake, flush and bubble insertion.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module if_id_pipe_stage #(
   parameter int unsigned              PC_W      = 10,
   parameter int unsigned              INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]       NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst,
   if_id_pipe_stage_if.slave bus
);

   logic               out_valid_q;
   logic [PC_W-1:0]    out_pc_q;
   logic [INSTR_W-1:0] out_instr_q;
   logic               in_ready;
   logic               take_in;
   logic               take_out;

   assign bus.out_valid = out_valid_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.out_instr = out_instr_q;
   assign bus.in_ready  = in_ready;
   assign take_in       = bus.in_valid && in_ready;

`ifdef PIPE_SKID_EN

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t             state;
   logic               in_ready_q;
   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   assign in_ready = in_ready_q;
   assign take_out = (state != EMPTY) && bus.out_ready;

   // in_ready_q tracks (next state != FULL) so it never depends on out_ready this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= NOP_INSTR;
         skid_pc     <= '0;
         skid_instr  <= NOP_INSTR;
         in_ready_q  <= 1'b0;
      end else if (bus.flush) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= NOP_INSTR;
         skid_pc     <= '0;
         skid_instr  <= NOP_INSTR;
         in_ready_q  <= 1'b1;
      end else begin
         in_ready_q <= 1'b1;
         case (state)
            EMPTY: begin
               if (take_in) begin
                  state       <= ONE;
                  out_valid_q <= 1'b1;
                  out_pc_q    <= bus.in_pc;
                  out_instr_q <= bus.in_instr;
               end
            end
            ONE: begin
               if (take_in && take_out) begin
                  out_pc_q    <= bus.in_pc;
                  out_instr_q <= bus.in_instr;
               end else if (take_in) begin
                  state      <= FULL;
                  skid_pc    <= bus.in_pc;
                  skid_instr <= bus.in_instr;
                  in_ready_q <= 1'b0;
               end else if (take_out) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
                  out_pc_q    <= '0;
                  out_instr_q <= NOP_INSTR;
               end
            end
            FULL: begin
               if (take_out) begin
                  state       <= ONE;
                  out_pc_q    <= skid_pc;
                  out_instr_q <= skid_instr;
               end else begin
                  in_ready_q <= 1'b0;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               out_pc_q    <= '0;
               out_instr_q <= NOP_INSTR;
            end
         endcase
      end
   end

`else

   typedef enum logic {EMPTY, ONE} state_t;

   state_t state;

   assign in_ready = (state == EMPTY) || bus.out_ready;
   assign take_out = (state != EMPTY) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= NOP_INSTR;
      end else if (take_in) begin
         state       <= ONE;
         out_valid_q <= 1'b1;
         out_pc_q    <= bus.in_pc;
         out_instr_q <= bus.in_instr;
      end else if (take_out) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= NOP_INSTR;
      end
   end

`endif

endmodule
